// File: rtl/spi_slave_frame.sv
// Oversampled SPI slave: one {cmd, payload} frame per SS_n assertion, read data shifted out MSB first.
// rx_valid/err pulses land the cycle after the deciding CLK edge; tx side waits on tx_valid with optional timeout.
module spi_slave_frame #(
    parameter int PAY_W      = 8,
    parameter int DATA_W     = 8,
    parameter int TX_TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              MISO,
    output logic [PAY_W+1:0]  rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              err_abort,
    output logic              err_seq,
    output logic              err_timeout
);

    localparam int FRAME_W = PAY_W + 2;
    localparam int BC_W    = $clog2(FRAME_W + 1);
    localparam int TO_W    = (TX_TIMEOUT > 0) ? $clog2(TX_TIMEOUT + 1) : 1;
    localparam int TC_W    = $clog2(DATA_W + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RECV    = 3'd1;
    localparam logic [2:0] S_TX_WAIT = 3'd2;
    localparam logic [2:0] S_TX      = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME_W - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TX_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_MAX  = '1;
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(DATA_W);

    logic [2:0]         state;
    logic [FRAME_W-2:0] shift_reg;
    logic [BC_W-1:0]    bit_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic [DATA_W-1:0]  tx_sh;
    logic [TC_W-1:0]    tx_cnt;
    logic               rd_pend;
    logic [FRAME_W-1:0] frame_full;
    logic               in_transfer;

    // Frame as it stands including the bit being sampled on this edge.
    assign frame_full  = {shift_reg, MOSI};
    assign in_transfer = (state == S_RECV) || (state == S_TX_WAIT) || (state == S_TX);
    assign busy        = (state != S_IDLE);

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            to_cnt      <= '0;
            tx_sh       <= '0;
            tx_cnt      <= '0;
            rd_pend     <= 1'b0;
            MISO        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            err_abort   <= 1'b0;
            err_seq     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            err_abort   <= 1'b0;
            err_seq     <= 1'b0;
            err_timeout <= 1'b0;

            // Deselect mid-transfer beats every other event on the same edge.
            if (SS_n && in_transfer) begin
                state     <= S_IDLE;
                err_abort <= 1'b1;
                MISO      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!SS_n) begin
                            shift_reg <= {{(FRAME_W-2){1'b0}}, MOSI};
                            bit_cnt   <= BC_W'(1);
                            state     <= S_RECV;
                        end
                    end

                    S_RECV: begin
                        if (bit_cnt == BC_LAST) begin
                            rx_data <= frame_full;
                            case (frame_full[FRAME_W-1 -: 2])
                                CMD_WR_ADDR, CMD_WR_DATA: begin
                                    rx_valid <= 1'b1;
                                    state    <= S_DONE;
                                end
                                CMD_RD_ADDR: begin
                                    rx_valid <= 1'b1;
                                    rd_pend  <= 1'b1;
                                    state    <= S_DONE;
                                end
                                CMD_RD_DATA: begin
                                    if (rd_pend) begin
                                        rx_valid <= 1'b1;
                                        to_cnt   <= '0;
                                        state    <= S_TX_WAIT;
                                    end else begin
                                        err_seq <= 1'b1;
                                        state   <= S_DONE;
                                    end
                                end
                                default: state <= S_DONE;
                            endcase
                        end else begin
                            shift_reg <= frame_full[FRAME_W-2:0];
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end

                    S_TX_WAIT: begin
                        if (tx_valid) begin
                            tx_sh  <= tx_data << 1;
                            MISO   <= tx_data[DATA_W-1];
                            tx_cnt <= TC_W'(1);
                            state  <= S_TX;
                        end else if ((TX_TIMEOUT != 0) && (to_cnt == TO_LAST)) begin
                            err_timeout <= 1'b1;
                            rd_pend     <= 1'b0;
                            state       <= S_DONE;
                        end else if (to_cnt != TO_MAX) begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end

                    S_TX: begin
                        if (tx_cnt == TC_LAST) begin
                            MISO    <= 1'b0;
                            rd_pend <= 1'b0;
                            state   <= S_DONE;
                        end else begin
                            MISO   <= tx_sh[DATA_W-1];
                            tx_sh  <= tx_sh << 1;
                            tx_cnt <= tx_cnt + 1'b1;
                        end
                    end

                    S_DONE: begin
                        if (SS_n) begin
                            state <= S_IDLE;
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
